// File: rtl/fpga9685_pkg.sv
// rtl/fpga9685_pkg.sv - register map, channel config type and byte helpers for pwm_engine
package fpga9685_pkg;

    localparam logic [7:0] MODE1          = 8'h00;
    localparam logic [7:0] LED0_ON_L      = 8'h06;
    localparam logic [7:0] ALL_LED_ON_L   = 8'hFA;
    localparam logic [7:0] PRE_SCALE      = 8'hFE;
    localparam int         LED_STRIDE     = 4;
    localparam int         SLEEP_BIT      = 4;
    localparam logic [7:0] PRESCALE_MIN   = 8'd3;
    localparam logic [7:0] MODE1_RESET    = 8'h10;

    typedef struct packed {
        logic [11:0] on;
        logic [11:0] off;
        logic        full_on;
        logic        full_off;
    } pwm_chan_cfg_t;

    localparam pwm_chan_cfg_t CHAN_CFG_RESET = '{on: 12'd0, off: 12'd0, full_on: 1'b0, full_off: 1'b1};

    typedef enum logic [1:0] {
        SEL_ON_L  = 2'd0,
        SEL_ON_H  = 2'd1,
        SEL_OFF_L = 2'd2,
        SEL_OFF_H = 2'd3
    } led_byte_e;

    function automatic logic [7:0] cfg_byte(pwm_chan_cfg_t cfg, led_byte_e sel);
        case (sel)
            SEL_ON_L:  return cfg.on[7:0];
            SEL_ON_H:  return {3'b000, cfg.full_on, cfg.on[11:8]};
            SEL_OFF_L: return cfg.off[7:0];
            default:   return {3'b000, cfg.full_off, cfg.off[11:8]};
        endcase
    endfunction

    function automatic pwm_chan_cfg_t cfg_write(pwm_chan_cfg_t cfg, led_byte_e sel, logic [7:0] data);
        pwm_chan_cfg_t r;
        r = cfg;
        case (sel)
            SEL_ON_L:  r.on[7:0] = data;
            SEL_ON_H:  begin r.on[11:8] = data[3:0]; r.full_on = data[4]; end
            SEL_OFF_L: r.off[7:0] = data;
            default:   begin r.off[11:8] = data[3:0]; r.full_off = data[4]; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pwm_engine_if.sv
// rtl/pwm_engine_if.sv - byte register write/read bus between the I2C target and pwm_engine
interface pwm_engine_if;
    logic       wr_en_i;
    logic [7:0] wr_addr_i;
    logic [7:0] wr_data_i;
    logic [7:0] rd_addr_i;
    logic [7:0] rd_data_o;

    modport master (output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, input rd_data_o);
    modport slave  (input wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, output rd_data_o);
endinterface

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: staging/active config, compare, registered output (PWM_SHADOW_EN)
module pwm_channel
    import fpga9685_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [1:0]    wr_sel_i,
    input  logic [7:0]    wr_data_i,
    input  logic          load_i,
    input  logic          force_off_i,
    input  logic [11:0]   cnt_i,
    output pwm_chan_cfg_t stg_cfg_o,
    output logic          pwm_o
);

    pwm_chan_cfg_t stg_cfg;
    pwm_chan_cfg_t act_cfg;
    logic          level;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stg_cfg <= CHAN_CFG_RESET;
        end else if (wr_en_i) begin
            stg_cfg <= cfg_write(stg_cfg, led_byte_e'(wr_sel_i), wr_data_i);
        end
    end

`ifdef PWM_SHADOW_EN
    // A write on the wrap edge lands in staging only; the load sees the old value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_cfg <= CHAN_CFG_RESET;
        end else if (load_i) begin
            act_cfg <= stg_cfg;
        end
    end
`else
    logic unused_load;
    assign unused_load = load_i;
    assign act_cfg     = stg_cfg;
`endif

    always_comb begin
        level = 1'b0;
        if (act_cfg.full_off) begin
            level = 1'b0;
        end else if (act_cfg.full_on) begin
            level = 1'b1;
        end else if (act_cfg.on == act_cfg.off) begin
            level = 1'b0;
        end else if (act_cfg.on < act_cfg.off) begin
            level = (cnt_i >= act_cfg.on) && (cnt_i < act_cfg.off);
        end else begin
            level = (cnt_i >= act_cfg.on) || (cnt_i < act_cfg.off);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_o <= 1'b0;
        end else begin
            pwm_o <= force_off_i ? 1'b0 : level;
        end
    end

    assign stg_cfg_o = stg_cfg;

endmodule

// File: rtl/pwm_engine.sv
// rtl/pwm_engine.sv - multi-channel 12-bit PWM with prescaled phase counter (PWM_SHADOW_EN double-buffers)
module pwm_engine
    import fpga9685_pkg::*;
#(
    parameter int         CHANNELS       = 16,
    parameter logic [7:0] PRESCALE_RESET = 8'd30
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    pwm_engine_if.slave         bus,
    output logic [CHANNELS-1:0] pwm_o,
    output logic                period_start_o
);

    localparam logic [7:0] LED_LAST     = 8'(int'(LED0_ON_L) + CHANNELS * LED_STRIDE - 1);
    localparam logic [7:0] ALL_LED_LAST = ALL_LED_ON_L + 8'd3;

    logic [7:0]    mode1;
    logic [7:0]    prescale_stg;
    logic [7:0]    prescale_act;
    logic [7:0]    divider;
    logic [11:0]   cnt;
    logic          sleep;
    logic          tick;
    logic          wrap;
    logic [7:0]    wr_off;
    logic [1:0]    all_sel;
    logic          led_wr_hit;
    logic          all_wr_hit;
    logic [7:0]    rd_off;
    logic          rd_led_hit;
    logic [7:0]    rd_mux;
    pwm_chan_cfg_t stg_cfg [CHANNELS];

    assign sleep = mode1[SLEEP_BIT];
    // >= rather than == keeps the divider bounded if PRE_SCALE drops below it
    assign tick  = !sleep && (divider >= prescale_act);
    assign wrap  = tick && (cnt == 12'hFFF);

    assign wr_off     = bus.wr_addr_i - LED0_ON_L;
    assign all_sel    = bus.wr_addr_i[1:0] - ALL_LED_ON_L[1:0];
    assign led_wr_hit = (bus.wr_addr_i >= LED0_ON_L) && (bus.wr_addr_i <= LED_LAST);
    assign all_wr_hit = (bus.wr_addr_i >= ALL_LED_ON_L) && (bus.wr_addr_i <= ALL_LED_LAST);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        logic ch_wr;
        assign ch_wr = bus.wr_en_i && (all_wr_hit || (led_wr_hit && (wr_off[7:2] == 6'(n))));

        pwm_channel u_chan (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .wr_en_i     (ch_wr),
            .wr_sel_i    (all_wr_hit ? all_sel : wr_off[1:0]),
            .wr_data_i   (bus.wr_data_i),
            .load_i      (wrap || sleep),
            .force_off_i (sleep),
            .cnt_i       (cnt),
            .stg_cfg_o   (stg_cfg[n]),
            .pwm_o       (pwm_o[n])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode1        <= MODE1_RESET;
            prescale_stg <= PRESCALE_RESET;
        end else if (bus.wr_en_i) begin
            if (bus.wr_addr_i == MODE1) begin
                mode1 <= bus.wr_data_i;
            end
            if (bus.wr_addr_i == PRE_SCALE) begin
                prescale_stg <= (bus.wr_data_i < PRESCALE_MIN) ? PRESCALE_MIN : bus.wr_data_i;
            end
        end
    end

`ifdef PWM_SHADOW_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prescale_act <= PRESCALE_RESET;
        end else if (wrap || sleep) begin
            prescale_act <= prescale_stg;
        end
    end
`else
    assign prescale_act = prescale_stg;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            divider        <= 8'd0;
            cnt            <= 12'd0;
            period_start_o <= 1'b0;
        end else begin
            period_start_o <= wrap;
            if (sleep) begin
                divider <= 8'd0;
                cnt     <= 12'd0;
            end else if (tick) begin
                divider <= 8'd0;
                cnt     <= cnt + 12'd1;
            end else begin
                divider <= divider + 8'd1;
            end
        end
    end

    assign rd_off     = bus.rd_addr_i - LED0_ON_L;
    assign rd_led_hit = (bus.rd_addr_i >= LED0_ON_L) && (bus.rd_addr_i <= LED_LAST);

    always_comb begin
        rd_mux = 8'h00;
        if (bus.rd_addr_i == MODE1) begin
            rd_mux = mode1;
        end else if (bus.rd_addr_i == PRE_SCALE) begin
            rd_mux = prescale_stg;
        end else if (rd_led_hit) begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (rd_off[7:2] == 6'(n)) begin
                    rd_mux = cfg_byte(stg_cfg[n], led_byte_e'(rd_off[1:0]));
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.rd_data_o <= 8'h00;
        end else begin
            bus.rd_data_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pwm_engine.sv
// tb/tb_pwm_engine.sv - scoreboard bench for pwm_engine
`timescale 1ns/1ps
module tb_pwm_engine;

    localparam int CH     = 16;
    localparam int PERIOD = 4 * 4096;

`ifdef PWM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic          clk_i  = 1'b0;
    logic          rst_ni = 1'b0;
    logic [CH-1:0] pwm_o;
    logic          period_start_o;

    pwm_engine_if bus ();

    pwm_engine #(.CHANNELS(CH), .PRESCALE_RESET(8'd30)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .bus            (bus),
        .pwm_o          (pwm_o),
        .period_start_o (period_start_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       n_checks = 0;
    int       n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_pop_check(input logic [31:0] got);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 1);
        end else begin
            it = sb_q.pop_front();
            check(it.tag, got, it.exp);
        end
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk_i);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = addr;
        bus.wr_data_i = data;
        @(negedge clk_i);
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic reg_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        @(negedge clk_i);
        bus.rd_addr_i = addr;
        sb_push(tag, exp);
        @(negedge clk_i);
        sb_pop_check(32'(bus.rd_data_o));
    endtask

    task automatic wait_ps(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
        end while (!period_start_o && k < 2 * PERIOD);
        check(tag, 32'(period_start_o), 1);
    endtask

    // Window starts on the sample where period_start_o is high; pops 4 channel counts, pulses, pulse position, first sample.
    task automatic measure_period(input bit do_wr, input logic [7:0] wa, input logic [7:0] wd);
        int hi [4];
        int ps_n;
        int ps_at;
        int first;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        ps_n  = 0;
        ps_at = 0;
        first = 0;
        for (int j = 1; j <= PERIOD; j++) begin
            @(negedge clk_i);
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm_o[c]);
            if (j == 1) first = int'(pwm_o[3:0]);
            if (period_start_o) begin
                ps_n++;
                ps_at = j;
            end
            if (do_wr && j == 2000) begin
                bus.wr_en_i   = 1'b1;
                bus.wr_addr_i = wa;
                bus.wr_data_i = wd;
            end
            if (j == 2001) bus.wr_en_i = 1'b0;
        end
        for (int c = 0; c < 4; c++) sb_pop_check(32'(hi[c]));
        sb_pop_check(32'(ps_n));
        sb_pop_check(32'(ps_at));
        sb_pop_check(32'(first));
    endtask

    task automatic push_period(input string p, input int ch0_hi);
        sb_push({p, "_ch0_high"}, 32'(ch0_hi));
        sb_push({p, "_ch1_high"}, 32'(2096 * 4));
        sb_push({p, "_ch2_high"}, 32'(PERIOD));
        sb_push({p, "_ch3_high"}, 0);
        sb_push({p, "_ps_count"}, 1);
        sb_push({p, "_ps_pos"}, 32'(PERIOD));
        sb_push({p, "_first_sample"}, 'h7);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en_i   = 1'b0;
        bus.wr_addr_i = 8'h00;
        bus.wr_data_i = 8'h00;
        bus.rd_addr_i = 8'h00;
        repeat (3) @(negedge clk_i);
        check("rst_pwm", 32'(pwm_o), 0);
        check("rst_rd", 32'(bus.rd_data_o), 0);
        check("rst_ps", 32'(period_start_o), 0);
        rst_ni = 1'b1;

        reg_read(8'h00, 'h10, "mode1_rst");
        reg_read(8'hFE, 30, "prescale_rst");
        reg_read(8'h09, 'h10, "ch0_off_h_rst");
        reg_read(8'h06, 'h00, "ch0_on_l_rst");
        reg_read(8'h03, 'h00, "unmapped_rd");
        reg_write(8'h03, 8'h55);
        reg_read(8'h03, 'h00, "unmapped_wr");
        reg_write(8'hFE, 8'd1);
        reg_read(8'hFE, 3, "prescale_clamp");
        reg_write(8'hFE, 8'd200);
        reg_read(8'hFE, 200, "prescale_rw");
        reg_write(8'hFE, 8'd3);
        reg_write(8'h0D, 8'hFF);
        reg_read(8'h0D, 'h1F, "off_h_mask");

        // ch1 ON=3000 OFF=1000, ch2 FULL_ON with reset FULL_OFF
        reg_write(8'h0A, 8'hB8);
        reg_write(8'h0B, 8'h0B);
        reg_write(8'h0C, 8'hE8);
        reg_write(8'h0D, 8'h03);
        reg_write(8'h0F, 8'h10);
        reg_read(8'h0B, 'h0B, "ch1_on_h");
        reg_read(8'h0C, 'hE8, "ch1_off_l");
        reg_read(8'h11, 'h10, "ch2_off_h");

        reg_write(8'h00, 8'h21);
        reg_read(8'h00, 'h21, "mode1_rw");
        reg_write(8'h06, 8'h00);
        reg_write(8'h07, 8'h00);
        reg_write(8'h08, 8'h00);
        reg_write(8'h09, 8'h08);
        reg_write(8'h11, 8'h00);
        repeat (2) @(negedge clk_i);
        check("ch0_before_wrap", 32'(pwm_o[0]), SHADOW ? 0 : 1);
        check("ch2_before_wrap", 32'(pwm_o[2]), SHADOW ? 0 : 1);

        wait_ps("first_wrap");
        check("ch0_at_wrap", 32'(pwm_o[0]), 0);
        check("ch2_at_wrap", 32'(pwm_o[2]), SHADOW ? 0 : 1);

        push_period("p1", 2048 * 4);
        measure_period(1'b0, 8'h00, 8'h00);

        push_period("p2", SHADOW ? 2048 * 4 : 1024 * 4);
        measure_period(1'b1, 8'h09, 8'h04);

        push_period("p3", 1024 * 4);
        measure_period(1'b0, 8'h00, 8'h00);

        reg_write(8'hFA, 8'h00);
        reg_write(8'hFB, 8'h00);
        reg_write(8'hFC, 8'h00);
        reg_write(8'hFD, 8'h08);
        reg_read(8'h1D, 'h08, "all_ch5_off_h");
        reg_read(8'h0F, 'h00, "all_ch2_on_h");
        reg_read(8'h45, 'h08, "all_ch15_off_h");
        reg_read(8'hFD, 'h00, "all_led_rd");
        wait_ps("all_wrap");
        repeat (100) @(negedge clk_i);
        check("all_high", 32'(pwm_o), 'hFFFF);

        reg_write(8'h00, 8'h10);
        @(negedge clk_i);
        check("sleep_pwm", 32'(pwm_o), 0);
        check("sleep_ps", 32'(period_start_o), 0);
        reg_read(8'h00, 'h10, "sleep_mode1");

        reg_write(8'h00, 8'h00);
        repeat (20) @(negedge clk_i);
        check("wake_high", 32'(pwm_o), 'hFFFF);
        reg_read(8'hFE, 3, "prescale_before_rst");

        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm_o), 0);
        check("async_rst_rd", 32'(bus.rd_data_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        reg_read(8'h00, 'h10, "mode1_after_rst");
        reg_read(8'h1D, 'h10, "ch5_off_h_after_rst");
        check("sb_drained", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
